// File: rtl/proc_pkg.sv
// Shared datapath definitions for the simple processor: data/address widths,
// register count, ALU select encodings and the common scalar typedefs.
package proc_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  // ALU operation select, shared with the operand mux and ALU.
  typedef enum logic [1:0] {
    FORWARD = 2'd0,
    ADD     = 2'd1,
    AND     = 2'd2,
    OR      = 2'd3
  } alu_sel_e;

endpackage : proc_pkg

// File: rtl/reg_file_8x8_wr_addr_decoder.sv
// Write-address decoder for the register file: turns the destination address
// plus the write strobe into a one-hot per-register enable vector.
module wr_addr_decoder #(
  parameter int ADDR_W = proc_pkg::ADDR_W
) (
  input  logic                  write_en,
  input  logic [ADDR_W-1:0]     in_addr,
  output logic [2**ADDR_W-1:0]  wr_en
);

  // One-hot enable; stays all-zero when no write is requested.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    wr_en = '0;
    if (write_en) begin
      wr_en[in_addr] = 1'b1;
    end
  end

endmodule : wr_addr_decoder

// File: rtl/reg_file_8x8.sv
// 8x8 register file for the simple-processor datapath: one write port fed by
// the ALU result, two registered read ports feeding the A/B operand selects,
// and a saturating count of accepted writes.
// Optional build macro REG_FILE_WRITE_BYPASS_EN: when defined, a read that hits
// the register being written on the same edge returns the incoming data
// instead of the old contents. Storage and WR_COUNT behave identically either way.
module reg_file_8x8 #(
  parameter int DATA_W = proc_pkg::DATA_W,
  parameter int ADDR_W = proc_pkg::ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              WRITE,
  input  logic [ADDR_W-1:0] INADDR,
  input  logic [DATA_W-1:0] IN,
  input  logic [ADDR_W-1:0] OUT1ADDR,
  input  logic [ADDR_W-1:0] OUT2ADDR,
  output logic [DATA_W-1:0] OUT1,
  output logic [DATA_W-1:0] OUT2,
  output logic [7:0]        WR_COUNT
);

  import proc_pkg::*;

  localparam int NREGS = 2 ** ADDR_W;
  localparam logic [7:0] WR_COUNT_MAX = 8'hFF;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [DATA_W-1:0] out1_q, out1_d;
  logic [DATA_W-1:0] out2_q, out2_d;
  logic [7:0]        wr_count_q, wr_count_d;
  logic [NREGS-1:0]  wr_en;

  wr_addr_decoder #(
    .ADDR_W (ADDR_W)
  ) u_wr_addr_decoder (
    .write_en (WRITE),
    .in_addr  (INADDR),
    .wr_en    (wr_en)
  );

  // Next-state: load the addressed register, fetch both read ports, bump the write count.
  always_comb begin
    for (int i = 0; i < NREGS; i++) begin
      regs_d[i] = wr_en[i] ? IN : regs_q[i];
    end

    // Reads see the contents from before this edge's write.
    out1_d = regs_q[OUT1ADDR];
    out2_d = regs_q[OUT2ADDR];
`ifdef REG_FILE_WRITE_BYPASS_EN
    // Forward the incoming write data to any port reading the same register.
    if (WRITE && (OUT1ADDR == INADDR)) out1_d = IN;
    if (WRITE && (OUT2ADDR == INADDR)) out2_d = IN;
`endif

    wr_count_d = wr_count_q;
    if (WRITE && (wr_count_q != WR_COUNT_MAX)) begin
      wr_count_d = wr_count_q + 8'd1;
    end
  end

  // State registers with synchronous reset; reset wins over a same-edge write.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      // NOTE: the storage array is reset explicitly because the datapath relies on registers reading 0 after reset.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
      out1_q     <= '0;
      out2_q     <= '0;
      wr_count_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      out1_q     <= out1_d;
      out2_q     <= out2_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign OUT1     = out1_q;
  assign OUT2     = out2_q;
  assign WR_COUNT = wr_count_q;

endmodule : reg_file_8x8

// File: doc/reg_file_8x8.md
Name: reg_file_8x8

Overview:
- Write-side counterpart to the 8-bit operand select mux in the simple-processor datapath.
- The mux picks one of several 8-bit sources onto one path. This block takes the single 8-bit result path (ALU output) and routes it into one of eight 8-bit registers.
- Two independent read ports supply the ALU's A/B operands.
- Sits between ALU result and operand-select mux; driven by the control unit's decoded write-enable and register addresses.

Parameters:
- DATA_W, 8, width of each register and of all data ports
- ADDR_W, 3, register address width; register count is 2**ADDR_W (8)

Ports:
- CLK  input  1  system clock, all state updates on rising edge
- RESET  input  1  synchronous, active-high reset
- WRITE  input  1  write enable for the write port
- INADDR  input  ADDR_W  destination register address
- IN  input  DATA_W  write data (ALU result)
- OUT1ADDR  input  ADDR_W  read port 1 address
- OUT2ADDR  input  ADDR_W  read port 2 address
- OUT1  output  DATA_W  read port 1 data (registered)
- OUT2  output  DATA_W  read port 2 data (registered)
- WR_COUNT  output  8  count of accepted writes since reset, saturating

Behaviour:
- Clock and reset: one clock, CLK. RESET is synchronous and active-high, sampled on the CLK rising edge.
- Reset:
  - While RESET=1 at a rising edge: all 8 registers <= 0, OUT1 <= 0, OUT2 <= 0, WR_COUNT <= 0.
  - RESET has priority over WRITE in the same cycle; that write is dropped.
  - Reset mid-sequence discards any in-flight read data. Outputs read 0 on the first cycle after RESET deasserts.
- Write:
  - On a rising edge with RESET=0 and WRITE=1: reg[INADDR] <= IN.
  - Address decoded one-hot; exactly one register updated, all others hold.
  - WRITE=0: no register changes.
  - Register 0 is an ordinary writable register, not hardwired to zero.
- Read:
  - On every rising edge with RESET=0: OUT1 <= reg[OUT1ADDR], OUT2 <= reg[OUT2ADDR].
  - Latency is 1 cycle from address to data.
  - Both ports may address the same register; both return the same value.
- Read/write collision (same edge, read address == INADDR, WRITE=1):
  - Without the optional feature, OUT returns the pre-write contents.
  - The new value is visible on the following read.
- WR_COUNT:
  - Increments by 1 on each accepted write (RESET=0, WRITE=1).
  - Saturates at 255; no wrap-around.
- No handshake stalls: a write is accepted every cycle WRITE=1. Back-to-back writes to the same address leave the last value written.

Optional Feature:
- Macro: REG_FILE_WRITE_BYPASS_EN
- Defined: on a read/write collision, the read port returns IN, the data being written that edge. Applies independently to each port; requires RESET=0.
- Undefined: collision returns old contents, as described in Behaviour.
- Register contents and WR_COUNT are identical in both builds.

Decomposition:
- Shared package proc_pkg holds:
  - DATA_W and ADDR_W constants, and the NUM_REGS constant.
  - ALU select encodings shared with the datapath: FORWARD=0, ADD=1, AND=2, OR=3.
  - A reg_addr_t typedef and a data_t typedef.
- One natural sub-module: wr_addr_decoder. Pure combinational mapping of INADDR plus WRITE to an 8-bit one-hot enable vector; all-zero when WRITE=0.

Test Plan:
1. RESET=1 for 2 cycles after writing random data -> all 8 registers read 0 on both ports; WR_COUNT=0.
2. Write IN=8'h07 to reg 1, then 8'h03 to reg 2; read OUT1ADDR=1, OUT2ADDR=2 -> OUT1=7, OUT2=3 exactly one cycle after the address is applied.
3. Same-edge collision: reg 4 holds 8'h11; write 8'hAA to reg 4 while OUT1ADDR=4 -> OUT1=8'h11 without the macro, 8'hAA with it; OUT1=8'hAA on the next cycle in both builds.
4. RESET=1 and WRITE=1 (reg 5, 8'h55) on the same edge -> reg 5 reads 0 afterwards; WR_COUNT=0.
5. 300 consecutive writes with WRITE=1 -> WR_COUNT saturates at 255 and stays there.
6. WRITE=0 with IN=8'hFF and INADDR sweeping 0..7 -> no register changes; all reads return prior values.
